octave_sequencer: RTL

OCTAVE_SEQUENCER -- requirements
Module: octave_sequencer

---
 rtl/octave_pkg.sv | 20 ++
 rtl/wrap_counter.sv | 39 +++
 rtl/octave_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/octave_pkg.sv
// Shared types and default geometry for the octave input sequencer.
package octave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int DEF_WIDTH      = 420;
    localparam int DEF_HEIGHT     = 240;
    localparam int DEF_FLUSH_ROWS = 12;

    // clog2 that never yields a zero-width vector for a modulus of 1.
    function automatic int cnt_w(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD counter with enable, synchronous clear and a terminal-count flag.
module wrap_counter
    import octave_pkg::*;
#(
    parameter int MOD = 4,
    parameter int CW  = cnt_w(MOD)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          wrap
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign wrap  = (count_q == CW'(MOD - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/octave_sequencer.sv
// Feeds one frame of pixels into the octave window cascade, then drains it
// with FLUSH_ROWS rows of blanking samples and pulses frame_done.
module octave_sequencer
    import octave_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int FLUSH_ROWS = DEF_FLUSH_ROWS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] din,
    output logic       validin,
    output logic       blanking_in,
    output logic       busy,
    output logic       frame_done
);

    localparam int FLUSH_LEN = FLUSH_ROWS * WIDTH;
    localparam int COL_W     = cnt_w(WIDTH);
    localparam int ROW_W     = cnt_w(HEIGHT);
    localparam int FL_W      = cnt_w(FLUSH_LEN + 1);

    state_e     state_q, state_d;
    logic [7:0] din_q, din_d;
    logic       validin_q, validin_d;
    logic       blanking_q, blanking_d;
    logic       frame_done_q, frame_done_d;

    logic             xfer;
    logic             cnt_clr;
    logic             col_wrap, row_wrap, fl_wrap;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [FL_W-1:0]  fl_cnt;
    logic             cnt_unused;

    assign pix_ready = (state_q == ST_ACTIVE);
    assign busy      = (state_q != ST_IDLE);
    assign xfer      = pix_ready && pix_valid;
    assign cnt_clr   = (state_q == ST_IDLE) && start;

    // The FSM is steered by the wrap flags; raw counts are kept for observability.
    assign cnt_unused = ^{col_cnt, row_cnt, fl_cnt};

    wrap_counter #(.MOD(WIDTH), .CW(COL_W)) u_col (
        .clock (clock),
        .reset (reset),
        .en    (xfer),
        .clr   (cnt_clr),
        .count (col_cnt),
        .wrap  (col_wrap)
    );

    wrap_counter #(.MOD(HEIGHT), .CW(ROW_W)) u_row (
        .clock (clock),
        .reset (reset),
        .en    (xfer && col_wrap),
        .clr   (cnt_clr),
        .count (row_cnt),
        .wrap  (row_wrap)
    );

    // Counts 0..FLUSH_LEN: the first FLUSH_LEN cycles emit blanking, the last hands off to DONE.
    wrap_counter #(.MOD(FLUSH_LEN + 1), .CW(FL_W)) u_flush (
        .clock (clock),
        .reset (reset),
        .en    (state_q == ST_FLUSH),
        .clr   (cnt_clr),
        .count (fl_cnt),
        .wrap  (fl_wrap)
    );

    always_comb begin
        state_d      = state_q;
        din_d        = din_q;
        validin_d    = 1'b0;
        blanking_d   = 1'b1;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (xfer) begin
                    din_d      = pix_data;
                    validin_d  = 1'b1;
                    blanking_d = 1'b0;
                    if (col_wrap && row_wrap) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fl_wrap) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end else begin
                    din_d     = 8'd0;
                    validin_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            din_q        <= 8'd0;
            validin_q    <= 1'b0;
            blanking_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            validin_q    <= validin_d;
            blanking_q   <= blanking_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign din         = din_q;
    assign validin     = validin_q;
    assign blanking_in = blanking_q;
    assign frame_done  = frame_done_q;

endmodule
